div_sequencer: RTL



---
 rtl/div_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: iterative restoring divider for DIV/DIVU, one quotient bit per cycle,
// returning {remainder, quotient} and holding the pipeline via stallreq while in flight.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               flush,
    input  logic               hold,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy,
    output logic               stallreq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] rq_q, rq_d, result_q;
    logic [WIDTH-1:0]   dvs_q, abs1, abs2, q_fix, r_fix;
    logic [WIDTH:0]     trial;
    logic               qneg_q, rneg_q, ready_q;
    always_comb begin
        abs1  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        // trial uses the shifted-out remainder MSB so a 33-bit partial remainder is never lost
        trial = rq_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
        rq_d  = trial[WIDTH] ? {rq_q[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
        q_fix = qneg_q ? -rq_d[WIDTH-1:0] : rq_d[WIDTH-1:0];
        r_fix = rneg_q ? -rq_d[2*WIDTH-1:WIDTH] : rq_d[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rq_q     <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (flush || (state_q == RUN && !start)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (opdata2 != '0) begin
                        state_q <= RUN;
                        rq_q    <= {{WIDTH{1'b0}}, abs1};
                        dvs_q   <= abs2;
                        qneg_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        rneg_q  <= signed_div & opdata1[WIDTH-1];
                        cnt_q   <= '0;
                    end else begin
                        state_q  <= DONE;
                        result_q <= {opdata1, {WIDTH{1'b1}}};
                        ready_q  <= 1'b1;
                    end
                end
                RUN: begin
                    rq_q  <= rq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q  <= DONE;
                        result_q <= {r_fix, q_fix};
                        ready_q  <= 1'b1;
                    end
                end
                DONE: if (!hold) begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign result   = result_q;
    assign ready    = ready_q;
    assign busy     = state_q != IDLE;
    assign stallreq = start & ~ready_q & ~flush;
endmodule
